// File: rtl/i_memory_access.sv
// -----------------------------------------------------------------------------
// i_memory_access
//
// Memory-access stage of a 5-stage RV32 pipeline. Holds a small word-addressed
// data memory with byte-lane write enables, performs loads/stores of byte,
// halfword and word size, detects misaligned accesses, and registers the
// writeback information for the following stage (one cycle of latency).
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_reset_n         asynchronous active-low reset of the pipeline registers
//   i_valid           execute stage presents a valid instruction
//   i_stall           hold this stage: no capture, no memory write
//   i_ctrl_mem_read   instruction is a load
//   i_ctrl_mem_write  instruction is a store
//   i_ctrl_funct3     access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_ctrl_reg_write  instruction writes rd
//   i_IE_result       ALU result: memory byte address or pass-through data
//   i_IE_data_write   store data (rs2)
//   i_IE_rd_addr      destination register
//   o_MEM_valid       output holds a valid instruction
//   o_MEM_result      writeback data (formatted load data or ALU result)
//   o_MEM_rd_addr     destination register
//   o_MEM_reg_write   writeback enable
//   o_MEM_misaligned  access fault flag for the output instruction
// -----------------------------------------------------------------------------
module i_memory_access #(
    parameter int      DATA_WIDTH     = 32,
    parameter int      DATA_MEM_DEPTH = 64,
    localparam int     DATA_MEM_ADDR  = $clog2(DATA_MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_ctrl_mem_read,
    input  logic                  i_ctrl_mem_write,
    input  logic [2:0]            i_ctrl_funct3,
    input  logic                  i_ctrl_reg_write,
    input  logic [DATA_WIDTH-1:0] i_IE_result,
    input  logic [DATA_WIDTH-1:0] i_IE_data_write,
    input  logic [4:0]            i_IE_rd_addr,
    output logic                  o_MEM_valid,
    output logic [DATA_WIDTH-1:0] o_MEM_result,
    output logic [4:0]            o_MEM_rd_addr,
    output logic                  o_MEM_reg_write,
    output logic                  o_MEM_misaligned
);

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // -------------------------------------------------------------------------
    // Data memory
    // -------------------------------------------------------------------------
    logic [31:0] mem [DATA_MEM_DEPTH];

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    logic        valid_q,      valid_d;
    logic [4:0]  rd_addr_q,    rd_addr_d;
    logic [2:0]  funct3_q,     funct3_d;
    logic        mem_read_q,   mem_read_d;
    logic [1:0]  addr_lo_q,    addr_lo_d;
    logic [31:0] result_q,     result_d;
    logic        misaligned_q, misaligned_d;
    logic        reg_write_q,  reg_write_d;
    logic [31:0] rdata_q,      rdata_d;

    // -------------------------------------------------------------------------
    // Input-side decode
    // -------------------------------------------------------------------------
    logic                     accept;
    logic [DATA_MEM_ADDR-1:0] mem_idx;
    logic [1:0]               addr_lo;
    logic                     is_half;
    logic                     is_word;
    logic                     misaligned;
    logic                     mem_we;
    logic [3:0]               mem_be;
    logic [31:0]              mem_wdata;

    assign accept  = !i_stall;
    // Upper address bits are dropped, so accesses wrap around the memory.
    assign mem_idx = i_IE_result[DATA_MEM_ADDR+1:2];
    assign addr_lo = i_IE_result[1:0];
    // H and HU share funct3[1:0] = 01.
    assign is_half = (i_ctrl_funct3[1:0] == 2'b01);
    assign is_word = (i_ctrl_funct3 == F3_W);

    assign misaligned = i_valid
                      && (i_ctrl_mem_read || i_ctrl_mem_write)
                      && ((is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00)));

    assign mem_we = accept && i_valid && i_ctrl_mem_write && !misaligned;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path through the case statement leaves it unassigned (no latch).
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = i_IE_data_write;
        unique case (i_ctrl_funct3[1:0])
            2'b00: begin
                mem_be    = 4'b0001 << addr_lo;
                mem_wdata = {4{i_IE_data_write[7:0]}};
            end
            2'b01: begin
                mem_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{i_IE_data_write[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = i_IE_data_write;
            end
        endcase
    end

    // NOTE: the memory array has no reset; only the pipeline registers do.
    // Writes are additionally gated by reset so nothing is stored while it is
    // asserted.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state for the pipeline registers: capture on accept, hold on stall.
    // The read-data register samples the array before the same-edge store
    // lands, which gives read-first behaviour.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d      = valid_q;
        rd_addr_d    = rd_addr_q;
        funct3_d     = funct3_q;
        mem_read_d   = mem_read_q;
        addr_lo_d    = addr_lo_q;
        result_d     = result_q;
        misaligned_d = misaligned_q;
        reg_write_d  = reg_write_q;
        rdata_d      = rdata_q;
        if (accept) begin
            valid_d      = i_valid;
            rd_addr_d    = i_IE_rd_addr;
            funct3_d     = i_ctrl_funct3;
            mem_read_d   = i_ctrl_mem_read;
            addr_lo_d    = addr_lo;
            result_d     = i_IE_result;
            misaligned_d = misaligned;
            reg_write_d  = i_valid && i_ctrl_reg_write && !misaligned;
            rdata_d      = mem[mem_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q      <= 1'b0;
            rd_addr_q    <= '0;
            funct3_q     <= '0;
            mem_read_q   <= 1'b0;
            addr_lo_q    <= '0;
            result_q     <= '0;
            misaligned_q <= 1'b0;
            reg_write_q  <= 1'b0;
            rdata_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            rd_addr_q    <= rd_addr_d;
            funct3_q     <= funct3_d;
            mem_read_q   <= mem_read_d;
            addr_lo_q    <= addr_lo_d;
            result_q     <= result_d;
            misaligned_q <= misaligned_d;
            reg_write_q  <= reg_write_d;
            rdata_q      <= rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Load formatting on the registered word
    // -------------------------------------------------------------------------
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign load_byte = rdata_q[{addr_lo_q, 3'b000} +: 8];
    assign load_half = rdata_q[{addr_lo_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata_q;
        unique case (funct3_q)
            F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_data = {{16{load_half[15]}}, load_half};
            F3_BU:   load_data = {24'h0, load_byte};
            F3_HU:   load_data = {16'h0, load_half};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        o_MEM_result = result_q;
        if (mem_read_q) begin
            // A faulting load must not leak memory contents.
            o_MEM_result = misaligned_q ? '0 : load_data;
        end
    end

    assign o_MEM_valid      = valid_q;
    assign o_MEM_rd_addr    = rd_addr_q;
    assign o_MEM_reg_write  = reg_write_q;
    assign o_MEM_misaligned = misaligned_q;

endmodule

// File: doc/i_memory_access.md
I_MEMORY_ACCESS -- requirements
Module: i_memory_access

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 Parameter DATA_MEM_DEPTH, default 64, data memory depth in 32-bit words.
REQ-003 Parameter DATA_MEM_ADDR, default $clog2(DATA_MEM_DEPTH), word-index width; derived, not overridden.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  clock, all state on rising edge.
REQ-006 i_reset_n  in  1  asynchronous active-low reset.
REQ-007 i_valid  in  1  execute stage presents a valid instruction.
REQ-008 i_stall  in  1  hold this stage; no capture, no memory write.
REQ-009 i_ctrl_mem_read  in  1  instruction is a load.
REQ-010 i_ctrl_mem_write  in  1  instruction is a store.
REQ-011 i_ctrl_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 i_ctrl_reg_write  in  1  instruction writes rd.
REQ-013 i_IE_result  in  DATA_WIDTH  ALU result: memory byte address, or pass-through data.
REQ-014 i_IE_data_write  in  DATA_WIDTH  store data (rs2).
REQ-015 i_IE_rd_addr  in  5  destination register.
REQ-016 o_MEM_valid  out  1  output holds a valid instruction.
REQ-017 o_MEM_result  out  DATA_WIDTH  writeback data (load data or ALU result).
REQ-018 o_MEM_rd_addr  out  5  destination register.
REQ-019 o_MEM_reg_write  out  1  writeback enable.
REQ-020 o_MEM_misaligned  out  1  access fault flag for the output instruction.

Function
REQ-021 Accept = rising edge with i_stall=0; latency is 1 cycle from accept to outputs.
REQ-022 On accept, register valid, rd_addr, funct3, mem_read, address bits [1:0], the ALU result and the misaligned flag.
REQ-023 Memory word index = i_IE_result[DATA_MEM_ADDR+1:2]; higher address bits are ignored, so addresses wrap modulo DATA_MEM_DEPTH*4.
REQ-024 Memory read is synchronous: the addressed word is registered on accept; the read is read-first (same-edge store to the same word returns the old data).
REQ-025 Misaligned = valid and (read or write) and ((H/HU and addr[0]=1) or (W and addr[1:0]!=0)).
REQ-026 Store occurs on accept when i_valid=1, i_ctrl_mem_write=1 and the access is not misaligned.
REQ-027 Store byte enables: B sets one lane at addr[1:0]; H sets lanes {addr[1],0} and {addr[1],1}; W sets all four lanes.
REQ-028 Store data is replicated: byte to all lanes, halfword to both halves.
REQ-029 Load formatting is combinational on the registered word: select the byte or half by the registered addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU); W passes the word through.
REQ-030 o_MEM_result = formatted load data when registered mem_read=1, else the registered ALU result.
REQ-031 o_MEM_reg_write = registered (valid and reg_write and not misaligned).
REQ-032 On a misaligned load, o_MEM_result=0, o_MEM_misaligned=1 and no register write occurs.
REQ-033 i_valid=0 on accept: o_MEM_valid=0, o_MEM_reg_write=0, no store.
REQ-034 While i_stall=1, all output registers and the read-data register hold; store input is ignored.
REQ-035 Simultaneous mem_read and mem_write with valid: the store executes and the load returns the old word.

Reset
REQ-036 Asserting i_reset_n=0 immediately clears o_MEM_valid, o_MEM_reg_write, o_MEM_misaligned, o_MEM_result, o_MEM_rd_addr and all internal pipeline registers to 0, independent of the clock.
REQ-037 Memory contents are not reset; simulation initial contents are all zero.
REQ-038 No store occurs while reset is asserted; after release, the first accept follows normal rules.

Verification
REQ-039 SW 0xDEADBEEF to 0x10, then LW 0x10 -> o_MEM_result=0xDEADBEEF one cycle after the load is accepted, reg_write=1.
REQ-040 SB 0x80 to 0x13; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-041 LH 0x11 -> misaligned=1, result=0, reg_write=0; SW 0x12 -> memory unchanged, misaligned=1.
REQ-042 Load accepted, then i_stall=1 for 2 cycles with an SW presented -> outputs hold their values and the memory is not written.
REQ-043 Mid-stream i_reset_n=0 between edges -> all outputs are 0 before the next edge; after release, LW returns the pre-reset stored data.
REQ-044 Non-memory op, i_IE_result=0x1234, rd=5 -> o_MEM_result=0x1234, rd_addr=5, reg_write=1 one cycle later; wrap: SW to 0x100 with depth 64 is readable at 0x000.
